// File: rtl/bus_mem_pkg.sv
// Shared rv32i memory-bus definitions: per-port read-state encoding, RAM
// defaults and the address-window helper used by the bus front end.
package bus_mem_pkg;

    localparam int          DEF_WORDS = 4096;
    localparam logic [31:0] DEF_BASE  = 32'h0000_0000;

    localparam logic [0:0]  RD_IDLE   = 1'b0;
    localparam logic [0:0]  RD_VALID  = 1'b1;

    // True when byte address a lies in the 2**(aw+2)-byte window starting at base.
    function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                       input int aw);
        logic [31:0] off;
        off = a - base;
        return (off >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/bus_mem_spram_bw.sv
// Single-port RAM with per-byte write enables and a registered read port.
// A write cycle leaves the read register untouched.
module spram_bw #(
    parameter int WORDS     = 4096,
    parameter     INIT_FILE = "",
    localparam int AW       = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
            if (we_i == 4'b0000) rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_mem.sv
// Dual-requester (instruction read / data read-write) front end onto one
// byte-writable RAM; one RAM access per cycle, d write > d read > i read.
module bus_mem
    import bus_mem_pkg::*;
#(
    parameter int          WORDS     = DEF_WORDS,
    parameter logic [31:0] BASE      = DEF_BASE,
    parameter              INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_rstrb,
    output logic [31:0] i_rdata,
    output logic        i_rbusy,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    input  logic        d_wstrb,
    input  logic        d_rstrb,
    output logic [31:0] d_rdata,
    output logic        d_rbusy,
    output logic        d_wbusy
);

    localparam int AW = $clog2(WORDS);

    logic [0:0]    i_state_q, i_state_d, d_state_q, d_state_d;
    logic          i_hit_q, i_hit_d, d_hit_q, d_hit_d;
    logic          i_hit, d_hit;
    logic          wr_gnt, dr_gnt, ir_gnt;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    // BASE is aligned to the RAM size, so the word index is just the raw address bits.
    assign i_hit = in_window(i_addr, BASE, AW);
    assign d_hit = in_window(d_addr, BASE, AW);

    always_comb begin
        wr_gnt    = !rst && d_wstrb && (d_state_q == RD_IDLE);
        dr_gnt    = !rst && d_rstrb && !d_wstrb && (d_state_q == RD_IDLE);
        ir_gnt    = !rst && i_rstrb && (i_state_q == RD_IDLE) && !wr_gnt && !dr_gnt;

        ram_en    = (wr_gnt && d_hit) || dr_gnt || ir_gnt;
        ram_we    = (wr_gnt && d_hit) ? d_wmask : 4'b0000;
        ram_addr  = (wr_gnt || dr_gnt) ? d_addr[AW+1:2] : i_addr[AW+1:2];

        // VALID lasts exactly one cycle whether or not the strobe is still up.
        d_state_d = dr_gnt ? RD_VALID : RD_IDLE;
        i_state_d = ir_gnt ? RD_VALID : RD_IDLE;
        d_hit_d   = dr_gnt && d_hit;
        i_hit_d   = ir_gnt && i_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state_q <= RD_IDLE;
            d_state_q <= RD_IDLE;
            i_hit_q   <= 1'b0;
            d_hit_q   <= 1'b0;
        end else begin
            i_state_q <= i_state_d;
            d_state_q <= d_state_d;
            i_hit_q   <= i_hit_d;
            d_hit_q   <= d_hit_d;
        end
    end

    spram_bw #(
        .WORDS     (WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (d_wdata),
        .rdata_o (ram_rdata)
    );

    assign i_rbusy = i_rstrb && (i_state_q != RD_VALID);
    assign d_rbusy = d_rstrb && (d_state_q != RD_VALID);
    assign d_wbusy = d_wstrb && !wr_gnt;

    // Out-of-window reads and idle ports present zero.
    assign i_rdata = ((i_state_q == RD_VALID) && i_hit_q) ? ram_rdata : 32'h0;
    assign d_rdata = ((d_state_q == RD_VALID) && d_hit_q) ? ram_rdata : 32'h0;

endmodule

// File: doc/bus_mem.md
BUS_MEM -- requirements
Module: bus_mem

Interface
REQ-001 SHALL have parameter WORDS, default 4096: RAM depth in 32-bit words, power of two.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000: byte address of word 0, aligned to WORDS*4.
REQ-003 SHALL have parameter INIT_FILE, default "" (empty): hex image loaded at elaboration; empty means no load.
REQ-004 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_addr, input, 32 bits: instruction read byte address.
REQ-007 SHALL have port i_rstrb, input, 1 bit: instruction read request, level, held until accepted.
REQ-008 SHALL have port i_rdata, output, 32 bits: instruction read data.
REQ-009 SHALL have port i_rbusy, output, 1 bit: instruction read not yet complete.
REQ-010 SHALL have port d_addr, input, 32 bits: data byte address.
REQ-011 SHALL have port d_wdata, input, 32 bits: store data, lanes pre-replicated by the requester.
REQ-012 SHALL have port d_wmask, input, 4 bits: byte enables; bit n selects wdata[8n+7:8n].
REQ-013 SHALL have port d_wstrb, input, 1 bit: write request, level.
REQ-014 SHALL have port d_rstrb, input, 1 bit: data read request, level.
REQ-015 SHALL have port d_rdata, output, 32 bits: data read data.
REQ-016 SHALL have port d_rbusy, output, 1 bit: data read not yet complete.
REQ-017 SHALL have port d_wbusy, output, 1 bit: write not yet performed.

Function
REQ-018 SHALL complete a transaction in any cycle where strobe=1 and the matching busy=0; the requester samples rdata in that same cycle.
REQ-019 SHALL keep a per-port read state: IDLE or VALID.
REQ-020 SHALL grant one RAM access per cycle, priority d write > d read > i read, to a port that is IDLE.
REQ-021 SHALL, when a read is granted, read word (addr-BASE)>>2 at that edge and move the port to VALID.
REQ-022 SHALL drive rbusy = rstrb AND state!=VALID (combinational), giving 1 busy cycle and completion on the second cycle.
REQ-023 SHALL drive rdata from the registered RAM output while VALID; value is otherwise don't-care.
REQ-024 SHALL return a VALID port to IDLE at the next edge unconditionally, including when rstrb has already dropped.
REQ-025 SHALL, for a granted write, drive d_wbusy=0 in the grant cycle and update only masked bytes at that edge.
REQ-026 SHALL drive d_wbusy=1 while d_wstrb=1 and no grant is given.
REQ-027 SHALL treat d_rstrb and d_wstrb both high as write first; the read is granted on a later cycle.
REQ-028 SHALL treat an i read losing to a d access as ungranted: i_rbusy stays 1 and the read retries next cycle.
REQ-029 SHALL ignore addr[1:0] and the address bits above the RAM size for word selection.
REQ-030 SHALL, for addresses outside [BASE, BASE+WORDS*4), return 32'h0 on reads and drop writes; handshake timing is unchanged.
REQ-031 SHALL give a d read the new data when the write to the same word completed on an earlier cycle.

Reset
REQ-032 SHALL on rst set both ports IDLE, i_rdata=d_rdata=0, i_rbusy=d_rbusy=d_wbusy=0 (strobes are low in reset); RAM contents are kept.
REQ-033 SHALL abandon any pending read when rst is asserted mid-transaction; no completion follows deassertion.

Structure
REQ-034 SHALL take the read-state encoding and BASE/WORDS defaults from the shared rv32i header package.
REQ-035 SHALL instantiate one sub-module spram_bw: single-port, byte-write-enable, registered-output RAM, one access per cycle.

Verification
REQ-036 SHALL cover i read: write 32'hDEADBEEF at 0x10, hold i_rstrb with i_addr=0x10 -> i_rbusy=1 for 1 cycle, then 0 with i_rdata=DEADBEEF.
REQ-037 SHALL cover byte store: word 0x20=32'h11223344, store wdata=32'hAAAAAAAA with wmask=0100 -> d_wbusy=0; later read returns 32'h11AA3344.
REQ-038 SHALL cover conflict: i_rstrb and d_wstrb raised in the same cycle -> write done that cycle; i_rbusy=1 for 2 cycles; i read sees the new data.
REQ-039 SHALL cover out of range: BASE=0, WORDS=4096, read 0x4000 -> 1 busy cycle, rdata=0; a write there leaves word 0 unchanged.
REQ-040 SHALL cover reset mid-read: rst in the VALID cycle -> next cycle all busy=0 and rdata=0; a new read takes the normal 2 cycles.
REQ-041 SHALL cover back-to-back d_rstrb held high 3 transactions at 0x0, 0x4, 0x8 -> completes every second cycle with the correct words.
